layer_weight_rx: RTL

//  Receiving end of the per-layer weight stream (64-bit valid/ready/last, 8 ch x 8 bit).

---
 rtl/layer_weight_rx_pkg.sv | 18 +
 rtl/layer_weight_rx_weight_bank_ram.sv | 35 +++
 rtl/layer_weight_rx.sv | 85 ++++++++
 3 files changed

// File: rtl/layer_weight_rx_pkg.sv
// Shared constants and FSM encoding for the per-layer weight receiver.
package layer_weight_rx_pkg;

  localparam int CH_NUM = 8;
  localparam int DATA_W = 8 * CH_NUM;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = $clog2(DEPTH);

  // Index of the beat that must carry weight_last in a well-formed burst.
  localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_weight_rx_weight_bank_ram.sv
// Simple dual-port weight bank: one write port, one read port with a
// registered, read-first output. Storage has no reset so it maps onto BRAM;
// only the output register is cleared.
module weight_bank_ram
  import layer_weight_rx_pkg::*;
(
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one beat per accepted transfer.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: sample the array before this edge's write lands (read-first).
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/layer_weight_rx.sv
// Receiver for one layer's weight burst: arms on start, stores DEPTH beats
// into the weight bank, checks the burst length against weight_last and then
// exposes the bank through a 1-cycle read port.
module layer_weight_rx
  import layer_weight_rx_pkg::*;
(
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] weight_data,
  input  logic              weight_valid,
  input  logic              weight_last,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W:0]   beat_cnt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t          state_reg;
  logic            done_reg;
  logic            len_err_reg;
  logic [ADDR_W:0] beat_cnt_reg;
  logic            accept;
  logic            at_last_slot;

  // ready comes straight from the state register, so a beat offered after the
  // terminating one is never accepted and there is no path from weight_valid.
  assign ready        = (state_reg == ST_LOAD);
  assign busy         = (state_reg == ST_LOAD);
  assign accept       = weight_valid & ready;
  assign at_last_slot = (beat_cnt_reg == LAST_BEAT);

  assign done     = done_reg;
  assign len_err  = len_err_reg;
  assign beat_cnt = beat_cnt_reg;

  // FSM, beat counter and length checker; done is a single-cycle pulse.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg    <= ST_IDLE;
      done_reg     <= 1'b0;
      len_err_reg  <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            len_err_reg  <= 1'b0;
            beat_cnt_reg <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (weight_last || at_last_slot) begin
              // Good only when last lands exactly on the final slot.
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              len_err_reg <= ~(weight_last & at_last_slot);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  weight_bank_ram u_bank (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .wr_en   (accept),
    .wr_addr (beat_cnt_reg[ADDR_W-1:0]),
    .wr_data (weight_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
